seven_seg_scan_ctrl: RTL and testbench

Multiplexed-display scan controller for the SevenSegDecoder datapath. It is an Avalon-MM slave that holds up to 8 hex digits. It time-shares one active-low segment bus across NUM_DIGITS common-anode digits by sequencing the digit enables, with a dead-time between digits to suppress ghosting. It sits between the HPS/Nios bus and the board display pins, in place of one decoder per digit.

---
 rtl/seven_seg_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: Avalon-MM slave that scans up to 8 hex digits across
// NUM_DIGITS common-anode displays on one shared active-low segment bus.
// Each digit slot is DRIVE (PRESCALE clocks) followed by BLANK (DEAD_CYCLES
// clocks) so the previous digit's segments never ghost onto the next one.
// Optional blink support is compiled in with `define SEVEN_SEG_SCAN_BLINK_EN.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int DEFAULT_PRESCALE = 50000,
    parameter int DEAD_CYCLES      = 2,
    parameter int BLINK_DIV        = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic [6:0]            segs,
    output logic [NUM_DIGITS-1:0] digit_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } state_e;

    localparam logic [2:0]  LAST_IDX  = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]  DEAD_LAST = 4'(DEAD_CYCLES - 1);
    localparam logic [23:0] PS_RESET  = 24'(DEFAULT_PRESCALE);

    // Active-low hex font, bit0 = segment a
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Register file
    logic [31:0] digits_q, digits_d;
    logic        enable_q, enable_d;
    logic [7:0]  mask_q, mask_d;
    logic [23:0] prescale_q, prescale_d;
    logic [31:0] readdata_q, readdata_d;

    // Scan state
    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]  dead_cnt_q, dead_cnt_d;
    logic [6:0]  segs_q, segs_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

    logic        wr_en, rd_en, ps_wr;
    logic [23:0] ps_eff;
    logic        slot_done, dead_done, frame_wrap;
    logic [7:0]  blink_dark;   // per-digit darkening from the blink phase

    assign wr_en  = chipselect & write;
    assign rd_en  = chipselect & read;
    assign ps_wr  = wr_en && (address == 3'd2);
    assign ps_eff = (prescale_q == 24'd0) ? 24'd1 : prescale_q;

    assign slot_done  = (slot_cnt_q == ps_eff - 24'd1);
    assign dead_done  = (dead_cnt_q == DEAD_LAST);
    assign frame_wrap = (state_q == S_BLANK) && enable_q && dead_done && (idx_q == LAST_IDX);

`ifdef SEVEN_SEG_SCAN_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  blink_off_q, blink_off_d;
    logic [7:0]            blink_mask8;

    assign blink_mask8 = 8'(blink_mask_q);
    assign blink_dark  = blink_off_d ? 8'(blink_mask_d) : 8'h00;

    // Blink mask register, frame counter and phase; idle parks the phase "on"
    always_comb begin
        blink_mask_d = blink_mask_q;
        frame_cnt_d  = frame_cnt_q;
        blink_off_d  = blink_off_q;
        if (wr_en && address == 3'd4)
            blink_mask_d = writedata[NUM_DIGITS-1:0];
        if (state_d == S_IDLE) begin
            frame_cnt_d = 16'd0;
            blink_off_d = 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt_q == 16'(BLINK_DIV - 1)) begin
                frame_cnt_d = 16'd0;
                blink_off_d = ~blink_off_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    // Blink state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_mask_q <= '0;
            frame_cnt_q  <= 16'd0;
            blink_off_q  <= 1'b0;
        end else begin
            blink_mask_q <= blink_mask_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_off_q  <= blink_off_d;
        end
    end
`else
    assign blink_dark = 8'h00;
`endif

    // Bus writes land at the accepting edge; unmapped bits are dropped
    always_comb begin
        digits_d   = digits_q;
        enable_d   = enable_q;
        mask_d     = mask_q;
        prescale_d = prescale_q;
        if (wr_en) begin
            case (address)
                3'd0: digits_d = writedata;
                3'd1: begin
                    enable_d = writedata[0];
                    mask_d   = writedata[15:8];
                end
                3'd2: prescale_d = writedata[23:0];
                default: ;
            endcase
        end
    end

    // Registered read mux; readdata holds between reads
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                3'd0: readdata_d = digits_q;
                3'd1: readdata_d = {16'd0, mask_q, 7'd0, enable_q};
                3'd2: readdata_d = {8'd0, prescale_q};
                3'd3: readdata_d = {23'd0, (state_q == S_DRIVE), 5'd0, idx_q};
`ifdef SEVEN_SEG_SCAN_BLINK_EN
                3'd4: readdata_d = 32'(blink_mask8);
`endif
                default: readdata_d = 32'd0;
            endcase
        end
    end

    // Scan FSM next state: a PRESCALE write restarts the current slot,
    // taking priority over its terminal count
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slot_cnt_d = slot_cnt_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            S_IDLE: begin
                idx_d      = 3'd0;
                slot_cnt_d = 24'd0;
                dead_cnt_d = 4'd0;
                if (enable_q) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (ps_wr) begin
                    slot_cnt_d = 24'd0;
                end else if (slot_done) begin
                    state_d    = S_BLANK;
                    dead_cnt_d = 4'd0;
                end else begin
                    slot_cnt_d = slot_cnt_q + 24'd1;
                end
            end
            S_BLANK: begin
                if (dead_done) begin
                    state_d    = S_DRIVE;
                    slot_cnt_d = 24'd0;
                    idx_d      = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                end else begin
                    dead_cnt_d = dead_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable_q) begin
            state_d    = S_IDLE;
            idx_d      = 3'd0;
            slot_cnt_d = 24'd0;
            dead_cnt_d = 4'd0;
        end
    end

    // Output decode from the upcoming state so pins change with the state
    always_comb begin
        segs_d     = 7'h7F;
        digit_en_d = '1;
        if (state_d == S_DRIVE && !mask_d[idx_d] && !blink_dark[idx_d]) begin
            segs_d = hex_decode(digits_d[{idx_d, 2'b00} +: 4]);
            for (int k = 0; k < NUM_DIGITS; k++)
                if (idx_d == 3'(k)) digit_en_d[k] = 1'b0;
        end
    end

    // All state, registers and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q   <= 32'd0;
            enable_q   <= 1'b0;
            mask_q     <= 8'd0;
            prescale_q <= PS_RESET;
            readdata_q <= 32'd0;
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            slot_cnt_q <= 24'd0;
            dead_cnt_q <= 4'd0;
            segs_q     <= 7'h7F;
            digit_en_q <= '1;
        end else begin
            digits_q   <= digits_d;
            enable_q   <= enable_d;
            mask_q     <= mask_d;
            prescale_q <= prescale_d;
            readdata_q <= readdata_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            segs_q     <= segs_d;
            digit_en_q <= digit_en_d;
        end
    end

    assign readdata = readdata_q;
    assign segs     = segs_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (NUM_DIGITS=4, DEAD_CYCLES=2).
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [6:0]  segs;
    logic [3:0]  digit_en;

    int checks = 0;
    int failures = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(4), .DEFAULT_PRESCALE(50000), .DEAD_CYCLES(2), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .read(read), .readdata(readdata),
        .segs(segs), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    // Hand-derived active-low patterns
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rd [4] = '{32'd0, 32'd0, 32'd50000, 32'd0};
        do_reset();
        checks++;
        if (segs !== 7'h7F || digit_en !== 4'hF || readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs segs=%h en=%h rd=%h want 7f/f/0", segs, digit_en, readdata);
        end
        for (int a = 0; a < 4; a++) begin
            bus_rd(3'(a), rd);
            checks++;
            if (rd !== exp_rd[a]) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h want=%h", a, rd, exp_rd[a]);
            end
        end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        do_reset();
        bus_wr(3'd2, 32'hAB12_3456);
        bus_wr(3'd1, 32'hFFFF_FF00);
        bus_wr(3'd5, 32'hFFFF_FFFF);
        bus_rd(3'd2, rd);
        checks++;
        if (rd !== 32'h0012_3456) begin
            failures++; $display("FAIL prescale_rb got=%h want=00123456", rd);
        end
        bus_rd(3'd1, rd);
        checks++;
        if (rd !== 32'h0000_FF00) begin
            failures++; $display("FAIL ctrl_rb got=%h want=0000ff00", rd);
        end
        bus_rd(3'd5, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL addr5_rb got=%h want=0", rd);
        end
`ifndef SEVEN_SEG_SCAN_BLINK_EN
        bus_wr(3'd4, 32'hF);
        bus_rd(3'd4, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL addr4_rb got=%h want=0", rd);
        end
`endif
        // chipselect low must block the write
        @(negedge clk);
        write = 1'b1; address = 3'd0; writedata = 32'h1234;
        @(negedge clk);
        write = 1'b0;
        bus_rd(3'd0, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL cs_low_write got=%h want=0", rd);
        end
    endtask

    // DRIVE entered one edge after the CTRL write edge; slot = 4 drive + 2 blank
    task automatic test_scan_timing();
        logic [3:0] nib [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        logic [3:0] een;
        logic [6:0] esg;
        int bad;
        do_reset();
        bus_wr(3'd2, 32'd4);
        bus_wr(3'd0, 32'h0000_4321);
        bus_wr(3'd1, 32'd1);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if ((k % 6) < 4) begin
                een = ~(4'b0001 << ((k / 6) % 4));
                esg = font[nib[(k / 6) % 4]];
            end else begin
                een = 4'hF; esg = 7'h7F;
            end
            checks++;
            if (digit_en !== een || segs !== esg) begin
                failures++; bad++;
                if (bad < 5)
                    $display("FAIL scan_cycle k=%0d en=%h segs=%h want en=%h segs=%h",
                             k, digit_en, segs, een, esg);
            end
        end
    endtask

    task automatic test_mask_decode();
        logic [3:0] een;
        logic [6:0] esg;
        logic [6:0] exp_sg [4] = '{7'h40, 7'h7F, 7'h00, 7'h0E};
        do_reset();
        bus_wr(3'd2, 32'd2);
        bus_wr(3'd0, 32'h0000_F8A0);
        bus_wr(3'd1, 32'h0000_0201);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if ((k % 4) < 2 && (k / 4) != 1) begin
                een = ~(4'b0001 << (k / 4));
                esg = exp_sg[k / 4];
            end else begin
                een = 4'hF; esg = 7'h7F;
            end
            checks++;
            if (digit_en !== een || segs !== esg) begin
                failures++;
                $display("FAIL mask_cycle k=%0d en=%h segs=%h want en=%h segs=%h",
                         k, digit_en, segs, een, esg);
            end
        end
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        int n;
        do_reset();
        bus_wr(3'd2, 32'd4);
        bus_wr(3'd0, 32'h0000_4321);
        bus_wr(3'd1, 32'd1);
        n = 0;
        while (digit_en !== 4'hB && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (digit_en !== 4'hB) begin
            failures++; $display("FAIL disable_reach_idx2 timeout en=%h want b", digit_en);
        end
        bus_wr(3'd1, 32'd0);
        @(negedge clk);
        checks++;
        if (segs !== 7'h7F || digit_en !== 4'hF) begin
            failures++; $display("FAIL disable_off segs=%h en=%h want 7f/f", segs, digit_en);
        end
        bus_rd(3'd3, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++; $display("FAIL disable_status got=%h want=0", rd);
        end
        bus_wr(3'd1, 32'd1);
        @(negedge clk);
        checks++;
        if (digit_en !== 4'hE || segs !== 7'h79) begin
            failures++; $display("FAIL reenable_idx0 en=%h segs=%h want e/79", digit_en, segs);
        end
    endtask

    task automatic test_back_to_back();
        int lows, highs, n;
        do_reset();
        bus_wr(3'd2, 32'd4);
        bus_wr(3'd1, 32'd1);
        // now in cycle before first DRIVE; third later negedge sits in drive cycle 3
        repeat (3) @(negedge clk);
        bus_wr(3'd2, 32'd6);     // accepted at the end of the last DRIVE cycle
        lows = 0;
        while (digit_en === 4'hE && lows < 40) begin
            lows++; @(negedge clk);
        end
        checks++;
        if (lows !== 6) begin
            failures++; $display("FAIL collision_slot_len got=%0d want=6", lows);
        end
        bus_wr(3'd2, 32'd0);
        n = 0;
        while (digit_en !== 4'hF && n < 40) begin
            @(negedge clk); n++;
        end
        while (digit_en === 4'hF && n < 80) begin
            @(negedge clk); n++;
        end
        lows = 0;
        while (digit_en !== 4'hF && lows < 40) begin
            lows++; @(negedge clk);
        end
        highs = 0;
        while (digit_en === 4'hF && highs < 40) begin
            highs++; @(negedge clk);
        end
        checks++;
        if (lows !== 1) begin
            failures++; $display("FAIL zero_prescale_len got=%0d want=1", lows);
        end
        checks++;
        if (highs !== 2) begin
            failures++; $display("FAIL dead_len got=%0d want=2", highs);
        end
    endtask

`ifdef SEVEN_SEG_SCAN_BLINK_EN
    // PRESCALE=1: 3-cycle slots, 12-cycle frames; digit 0 dark in frames 2,3 of every 4
    task automatic test_blink();
        logic [3:0] nib [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        logic [3:0] een;
        logic [6:0] esg;
        int slot;
        do_reset();
        bus_wr(3'd2, 32'd1);
        bus_wr(3'd0, 32'h0000_4321);
        bus_wr(3'd4, 32'h1);
        bus_wr(3'd1, 32'd1);
        for (int k = 0; k < 96; k++) begin
            @(negedge clk);
            slot = k / 3;
            if ((k % 3) == 0 && !((slot % 4) == 0 && ((slot / 4) % 4) >= 2)) begin
                een = ~(4'b0001 << (slot % 4));
                esg = font[nib[slot % 4]];
            end else begin
                een = 4'hF; esg = 7'h7F;
            end
            checks++;
            if (digit_en !== een || segs !== esg) begin
                failures++;
                $display("FAIL blink_cycle k=%0d en=%h segs=%h want en=%h segs=%h",
                         k, digit_en, segs, een, esg);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_regs();
        test_scan_timing();
        test_mask_decode();
        test_disable();
        test_back_to_back();
`ifdef SEVEN_SEG_SCAN_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
